cla_slice_add_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition as NCHUNK = WIDTH/CHUNK passes through one CHUNK-bit adder slice.
- The carry between slices is held in a registered carry flop.
- Operands are accepted and results returned over valid/ready handshakes.
- Sits between operand producers and result consumers, and lets a narrow carry-lookahead slice serve wide operands.

---
 rtl/cla_slice_add_ctrl_if.sv | 35 +++
 rtl/cla_slice_add_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/cla_slice_add_ctrl_if.sv
// Handshake bundle between operand producer, slice adder sequencer and result consumer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
//
// Ports (signals):
//   in_valid/in_ready      operand handshake, a/b/cin qualified by in_valid
//   out_valid/out_ready    result handshake, sum/cout/ovf qualified by out_valid
//   busy                   sequencer is running or holding a result
interface cla_slice_add_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/cla_slice_add_ctrl.sv
// Wide adder built from WIDTH/CHUNK passes through one CHUNK-bit slice, carry held in a flop.
// Latency: result valid right after the NCHUNK-th edge following the accept edge.
// Backpressure: one operation in flight; in_ready low in RUN/DONE, result held until out_ready.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   io         cla_slice_add_ctrl_if.slave: operand handshake (in_valid/in_ready, a, b, cin),
//              result handshake (out_valid/out_ready, sum, cout, ovf) and busy status
module cla_slice_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_slice_add_ctrl_if.slave  io
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_res;
    logic             last;

    // Slice selection as a constant-index mux so every part-select is static.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) begin
                a_sl = a_q[k*CHUNK +: CHUNK];
                b_sl = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    assign last      = (idx == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        a_q     <= io.a;
                        b_q     <= io.b;
                        carry_q <= io.cin;
                        idx     <= '0;
                        sum_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx == IDXW'(k)) begin
                            sum_q[k*CHUNK +: CHUNK] <= slice_res[CHUNK-1:0];
                        end
                    end
                    carry_q <= slice_res[CHUNK];
                    idx     <= idx + IDXW'(1);
                    if (last) begin
                        cout_q      <= slice_res[CHUNK];
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (slice_res[CHUNK-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is gated by rst so nothing is offered for capture while reset is held.
    assign io.in_ready  = !rst && (state == IDLE);
    assign io.busy      = (state == RUN) || (state == DONE);
    assign io.out_valid = out_valid_q;
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
endmodule
